// File: rtl/vid_pattern_gen.sv
// ---------------------------------------------------------------------------
// vid_pattern_gen
//   Video test-pattern source with built-in raster timing. Produces sync,
//   data-enable, frame-start and RGB888 pixel data for a selectable pattern:
//   grid, colour bars, checker, bouncing box, solid colour or black.
//   The requested mode and solid colour are sampled only at the end of a
//   frame, so a frame is never drawn with two patterns.
//
// Ports
//   clk              pixel clock
//   rst              asynchronous active-high reset
//   mode_sel[2:0]    requested pattern (0 grid, 1 bars, 2 checker, 3 box,
//                    4 solid, 5-7 black)
//   solid_rgb[23:0]  colour used by the solid pattern, {R,G,B}
//   out_data[23:0]   pixel {R,G,B}, zero outside the active region
//   out_hsync        horizontal sync, active-high
//   out_vsync        vertical sync, active-high
//   out_de           data enable (active region)
//   out_frame_start  one-cycle pulse with pixel (0,0)
//   frame_cnt[15:0]  number of completed frames, wraps
//
// All out_* signals are registered and describe the counter state of the
// previous cycle, so they are mutually aligned.
// ---------------------------------------------------------------------------
module vid_pattern_gen #(
   parameter int H_WIDTH  = 12,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int V_WIDTH  = 12,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int CHK_LOG2 = 5,
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  mode_sel,
   input  logic [23:0] solid_rgb,
   output logic [23:0] out_data,
   output logic        out_hsync,
   output logic        out_vsync,
   output logic        out_de,
   output logic        out_frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [H_WIDTH-1:0] HC_LAST  = H_WIDTH'(H_TOTAL - 1);
   localparam logic [H_WIDTH-1:0] HC_ACT   = H_WIDTH'(H_ACTIVE);
   localparam logic [H_WIDTH-1:0] HS_FIRST = H_WIDTH'(H_ACTIVE + H_FP);
   localparam logic [H_WIDTH-1:0] HS_LAST  = H_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [H_WIDTH-1:0] BAR_LAST = H_WIDTH'(BAR_W - 1);
   localparam logic [V_WIDTH-1:0] VC_LAST  = V_WIDTH'(V_TOTAL - 1);
   localparam logic [V_WIDTH-1:0] VC_ACT   = V_WIDTH'(V_ACTIVE);
   localparam logic [V_WIDTH-1:0] VS_FIRST = V_WIDTH'(V_ACTIVE + V_FP);
   localparam logic [V_WIDTH-1:0] VS_LAST  = V_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Box arithmetic is one bit wider so position+step/size cannot overflow.
   localparam logic [H_WIDTH:0] BX_MAX  = (H_WIDTH+1)'(H_ACTIVE - BOX_SIZE);
   localparam logic [H_WIDTH:0] BX_STEP = (H_WIDTH+1)'(BOX_STEP);
   localparam logic [H_WIDTH:0] BX_SIZE = (H_WIDTH+1)'(BOX_SIZE);
   localparam logic [V_WIDTH:0] BY_MAX  = (V_WIDTH+1)'(V_ACTIVE - BOX_SIZE);
   localparam logic [V_WIDTH:0] BY_STEP = (V_WIDTH+1)'(BOX_STEP);
   localparam logic [V_WIDTH:0] BY_SIZE = (V_WIDTH+1)'(BOX_SIZE);

   // Bar index advances until the last bar and then stays there, so the
   // remainder pixels of a width not divisible by 8 fall into bar 7.
   function automatic logic [2:0] bar_sat_inc(input logic [2:0] idx);
      return (idx == 3'd7) ? 3'd7 : idx + 3'd1;
   endfunction

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   logic [H_WIDTH-1:0] r_hc, r_bx, r_bar_px;
   logic [V_WIDTH-1:0] r_vc, r_by;
   logic               r_bx_neg, r_by_neg;
   logic [2:0]         r_mode, r_bar_idx;
   logic [23:0]        r_solid;

   logic               w_hc_last, w_vc_last, w_fe, w_active;
   logic [7:0]         w_x8, w_y8;
   logic               w_grid, w_in_box;
   logic [H_WIDTH:0]   w_bx_ext, w_hc_ext;
   logic [V_WIDTH:0]   w_by_ext, w_vc_ext;
   logic [H_WIDTH-1:0] w_bx_nxt;
   logic [V_WIDTH-1:0] w_by_nxt;
   logic               w_bx_neg_nxt, w_by_neg_nxt;
   logic [23:0]        w_pix;

   assign w_hc_last = (r_hc == HC_LAST);
   assign w_vc_last = (r_vc == VC_LAST);
   assign w_fe      = w_hc_last && w_vc_last;
   assign w_active  = (r_hc < HC_ACT) && (r_vc < VC_ACT);

   assign w_x8   = 8'(r_hc);
   assign w_y8   = 8'(r_vc);
   assign w_grid = (w_x8[3:0] == 4'd0) || (w_y8[3:0] == 4'd0);

   assign w_bx_ext = {1'b0, r_bx};
   assign w_by_ext = {1'b0, r_by};
   assign w_hc_ext = {1'b0, r_hc};
   assign w_vc_ext = {1'b0, r_vc};
   assign w_in_box = (w_hc_ext >= w_bx_ext) && (w_hc_ext < w_bx_ext + BX_SIZE) &&
                     (w_vc_ext >= w_by_ext) && (w_vc_ext < w_by_ext + BY_SIZE);

   // Next box position: clamp to the edge and reverse when a step would
   // leave the active area.
   always_comb begin
      w_bx_nxt     = r_bx;
      w_bx_neg_nxt = r_bx_neg;
      w_by_nxt     = r_by;
      w_by_neg_nxt = r_by_neg;
      if (!r_bx_neg) begin
         if (w_bx_ext + BX_STEP > BX_MAX) begin
            w_bx_nxt     = BX_MAX[H_WIDTH-1:0];
            w_bx_neg_nxt = 1'b1;
         end else begin
            w_bx_nxt = r_bx + BX_STEP[H_WIDTH-1:0];
         end
      end else begin
         if (w_bx_ext < BX_STEP) begin
            w_bx_nxt     = '0;
            w_bx_neg_nxt = 1'b0;
         end else begin
            w_bx_nxt = r_bx - BX_STEP[H_WIDTH-1:0];
         end
      end
      if (!r_by_neg) begin
         if (w_by_ext + BY_STEP > BY_MAX) begin
            w_by_nxt     = BY_MAX[V_WIDTH-1:0];
            w_by_neg_nxt = 1'b1;
         end else begin
            w_by_nxt = r_by + BY_STEP[V_WIDTH-1:0];
         end
      end else begin
         if (w_by_ext < BY_STEP) begin
            w_by_nxt     = '0;
            w_by_neg_nxt = 1'b0;
         end else begin
            w_by_nxt = r_by - BY_STEP[V_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      w_pix = 24'h000000;
      case (r_mode)
         3'd0:    w_pix = {w_x8, (w_grid ? 8'hFF : 8'h00), w_y8};
         3'd1:    w_pix = bar_colour(r_bar_idx);
         3'd2:    w_pix = (r_hc[CHK_LOG2] ^ r_vc[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
         3'd3:    w_pix = w_in_box ? 24'hFFFFFF : 24'h202020;
         3'd4:    w_pix = r_solid;
         default: w_pix = 24'h000000;
      endcase
   end

   // Stage 0: raster counters, bar tracker and frame-latched state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hc        <= '0;
         r_vc        <= '0;
         r_bar_px    <= '0;
         r_bar_idx   <= 3'd0;
         r_mode      <= 3'd0;
         r_solid     <= 24'h000000;
         r_bx        <= '0;
         r_by        <= '0;
         r_bx_neg    <= 1'b0;
         r_by_neg    <= 1'b0;
         frame_cnt   <= 16'd0;
      end else begin
         r_hc <= w_hc_last ? '0 : r_hc + H_WIDTH'(1);
         if (w_hc_last) begin
            r_vc <= w_vc_last ? '0 : r_vc + V_WIDTH'(1);
         end
         // Bar tracker follows the value hc takes on this edge.
         if (w_hc_last) begin
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
         end else if (r_bar_px == BAR_LAST) begin
            r_bar_px  <= '0;
            r_bar_idx <= bar_sat_inc(r_bar_idx);
         end else begin
            r_bar_px  <= r_bar_px + H_WIDTH'(1);
         end
         if (w_fe) begin
            r_mode    <= mode_sel;
            r_solid   <= solid_rgb;
            frame_cnt <= frame_cnt + 16'd1;
            r_bx      <= w_bx_nxt;
            r_by      <= w_by_nxt;
            r_bx_neg  <= w_bx_neg_nxt;
            r_by_neg  <= w_by_neg_nxt;
         end
      end
   end

   // Stage 1: registered outputs describing the stage-0 counter state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data        <= 24'h000000;
         out_hsync       <= 1'b0;
         out_vsync       <= 1'b0;
         out_de          <= 1'b0;
         out_frame_start <= 1'b0;
      end else begin
         out_data        <= w_active ? w_pix : 24'h000000;
         out_hsync       <= (r_hc >= HS_FIRST) && (r_hc <= HS_LAST);
         out_vsync       <= (r_vc >= VS_FIRST) && (r_vc <= VS_LAST);
         out_de          <= w_active;
         out_frame_start <= (r_hc == '0) && (r_vc == '0);
      end
   end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vid_pattern_gen
//   Directed bench for vid_pattern_gen using a shrunk raster
//   (28 x 18 total, 20 x 12 active) so whole frames can be captured and
//   inspected. Each frame is recorded into arrays starting at the
//   frame-start pulse; array index = y*28 + x.
// ---------------------------------------------------------------------------
module tb_vid_pattern_gen;

   localparam int HT    = 28;
   localparam int VT    = 18;
   localparam int HA    = 20;
   localparam int VA    = 12;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  mode_sel;
   logic [23:0] solid_rgb;
   logic [23:0] out_data;
   logic        out_hsync, out_vsync, out_de, out_frame_start;
   logic [15:0] frame_cnt;

   vid_pattern_gen #(
      .H_WIDTH(6), .H_FP(2), .H_SYNC(3), .H_BP(3), .H_ACTIVE(20),
      .V_WIDTH(5), .V_FP(2), .V_SYNC(2), .V_BP(2), .V_ACTIVE(12),
      .CHK_LOG2(2), .BOX_SIZE(8), .BOX_STEP(3)
   ) dut (
      .clk(clk), .rst(rst), .mode_sel(mode_sel), .solid_rgb(solid_rgb),
      .out_data(out_data), .out_hsync(out_hsync), .out_vsync(out_vsync),
      .out_de(out_de), .out_frame_start(out_frame_start), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cap_wait;

   logic [23:0] cap_d  [0:FRAME-1];
   logic        cap_de [0:FRAME-1];
   logic        cap_hs [0:FRAME-1];
   logic        cap_vs [0:FRAME-1];
   logic        cap_fs [0:FRAME-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for the frame-start pulse, then record one full frame.
   task automatic capture();
      cap_wait = 0;
      do begin
         @(negedge clk);
         cap_wait++;
      end while (!out_frame_start && cap_wait < 2 * FRAME);
      chk("fs_seen", out_frame_start, 1);
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge clk);
         cap_d[i]  = out_data;
         cap_de[i] = out_de;
         cap_hs[i] = out_hsync;
         cap_vs[i] = out_vsync;
         cap_fs[i] = out_frame_start;
      end
   endtask

   // Capture one frame while changing the requested mode partway through it.
   task automatic run_frame(input logic [2:0] nm, input logic [23:0] nrgb);
      fork
         capture();
         begin
            repeat (100) @(negedge clk);
            mode_sel  = nm;
            solid_rgb = nrgb;
         end
      join
      chk("fs_period", cap_wait, 1);
   endtask

   function automatic int count_fs();
      int n = 0;
      for (int i = 0; i < FRAME; i++) n += int'(cap_fs[i]);
      return n;
   endfunction

   int exp_bx [0:6] = '{12, 9, 6, 3, 0, 0, 3};
   int exp_by [0:6] = '{3, 4, 1, 0, 3, 4, 1};

   initial begin
      int n, x, y;
      logic [23:0] e;
      rst       = 1'b1;
      mode_sel  = 3'd0;
      solid_rgb = 24'h000000;
      repeat (3) @(negedge clk);
      chk("rst_data", out_data, 24'h0);
      chk("rst_de", out_de, 0);
      chk("rst_fs", out_frame_start, 0);
      chk("rst_fcnt", frame_cnt, 0);
      rst = 1'b0;

      // Frame 0: grid; mode 1 requested mid-frame must not show yet.
      run_frame(3'd1, 24'h0);
      chk("f0_fs0", cap_fs[0], 1);
      chk("f0_de0", cap_de[0], 1);
      chk("f0_fs_cnt", count_fs(), 1);
      chk("grid_0_0", cap_d[0], 24'h00FF00);
      chk("grid_16_5", cap_d[156], 24'h10FF05);
      chk("grid_17_5", cap_d[157], 24'h110005);
      chk("grid_17_0", cap_d[17], 24'h11FF00);
      chk("grid_3_7", cap_d[199], 24'h030007);
      chk("de_19", cap_de[19], 1);
      chk("de_20", cap_de[20], 0);
      chk("hblank_data", cap_d[20], 24'h0);
      chk("vblank_data", cap_d[339], 24'h0);
      chk("hs_21", cap_hs[21], 0);
      chk("hs_22", cap_hs[22], 1);
      chk("hs_24", cap_hs[24], 1);
      chk("hs_25", cap_hs[25], 0);
      chk("vs_391", cap_vs[391], 0);
      chk("vs_392", cap_vs[392], 1);
      chk("vs_447", cap_vs[447], 1);
      chk("vs_448", cap_vs[448], 0);
      n = 0; for (int i = 0; i < FRAME; i++) n += int'(cap_hs[i]);
      chk("hs_count", n, 54);
      n = 0; for (int i = 0; i < FRAME; i++) n += int'(cap_vs[i]);
      chk("vs_count", n, 56);
      n = 0; for (int i = 0; i < FRAME; i++) n += int'(cap_de[i]);
      chk("de_count", n, 240);

      // Frame 1: colour bars, bar width 2, pixels 16..19 stay in bar 7.
      run_frame(3'd2, 24'h0);
      chk("bar_px0", cap_d[0], 24'hFFFFFF);
      chk("bar_px2", cap_d[2], 24'hFFFF00);
      chk("bar_px4", cap_d[4], 24'h00FFFF);
      chk("bar_px6", cap_d[6], 24'h00FF00);
      chk("bar_px8", cap_d[8], 24'hFF00FF);
      chk("bar_px10", cap_d[10], 24'hFF0000);
      chk("bar_px13", cap_d[13], 24'h0000FF);
      chk("bar_px14", cap_d[14], 24'h000000);
      chk("bar_px16", cap_d[16], 24'h000000);
      chk("bar_px19", cap_d[19], 24'h000000);
      chk("bar_px20", cap_d[20], 24'h000000);
      chk("bar_l3_px3", cap_d[87], 24'hFFFF00);

      // Frame 2: checker with 4-pixel squares.
      run_frame(3'd4, 24'h123456);
      chk("chk_0_0", cap_d[0], 24'h000000);
      chk("chk_4_0", cap_d[4], 24'hFFFFFF);
      chk("chk_8_0", cap_d[8], 24'h000000);
      chk("chk_12_0", cap_d[12], 24'hFFFFFF);
      chk("chk_0_4", cap_d[112], 24'hFFFFFF);
      chk("chk_4_4", cap_d[116], 24'h000000);

      // Frame 3: solid colour; a new colour requested mid-frame is ignored.
      run_frame(3'd5, 24'hABCDEF);
      n = 0;
      for (int i = 0; i < FRAME; i++) begin
         x = i % HT; y = i / HT;
         e = (x < HA && y < VA) ? 24'h123456 : 24'h000000;
         if (cap_d[i] !== e) n++;
      end
      chk("solid_px_bad", n, 0);

      // Frame 4: mode 5 is black everywhere, timing unaffected.
      run_frame(3'd3, 24'h0);
      n = 0; for (int i = 0; i < FRAME; i++) if (cap_d[i] !== 24'h0) n++;
      chk("black_px_bad", n, 0);
      n = 0; for (int i = 0; i < FRAME; i++) n += int'(cap_de[i]);
      chk("black_de_count", n, 240);

      // Frames 5..11: bouncing box (size 8, step 3), positions hand-traced.
      for (int f = 0; f < 7; f++) begin
         run_frame(3'd3, 24'h0);
         n = 0;
         for (int i = 0; i < FRAME; i++) begin
            x = i % HT; y = i / HT;
            if (x < HA && y < VA)
               e = (x >= exp_bx[f] && x < exp_bx[f] + 8 && y >= exp_by[f] && y < exp_by[f] + 8)
                   ? 24'hFFFFFF : 24'h202020;
            else
               e = 24'h000000;
            if (cap_d[i] !== e) n++;
         end
         chk($sformatf("box_f%0d_bad", f + 5), n, 0);
      end
      chk("fcnt_12", frame_cnt, 12);

      // Asynchronous reset in the middle of an active line.
      mode_sel  = 3'd4;
      solid_rgb = 24'h654321;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_data", out_data, 24'h0);
      chk("arst_de", out_de, 0);
      chk("arst_hs", out_hsync, 0);
      chk("arst_vs", out_vsync, 0);
      chk("arst_fs", out_frame_start, 0);
      chk("arst_fcnt", frame_cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_frame(3'd4, 24'h654321);
      chk("post_rst_fs0", cap_fs[0], 1);
      chk("post_rst_de0", cap_de[0], 1);
      chk("post_rst_grid0", cap_d[0], 24'h00FF00);
      chk("post_rst_grid156", cap_d[156], 24'h10FF05);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
